fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    // Fetch FSM: buffer empty, request in flight, in-flight request to be
    // dropped after a redirect, buffer holding the instruction at pc.
    typedef enum logic [1:0] {
        EMPTY        = 2'd0,
        WAIT         = 2'd1,
        WAIT_DISCARD = 2'd2,
        FULL         = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0 -- shown to decode whenever no real instruction is held.
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, keeps at most one imem request in
// flight, buffers the returned word and presents it to the IF/ID register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallF,
    input  logic               PCSrcE,
    input  logic [31:0]        PCTargetE,
    fetch_unit_if.master       imem,
    output logic [31:0]        InstrF,
    output logic [31:0]        PCF,
    output logic [31:0]        PCPlus4F,
    output logic               InstrValidF
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_buf;
    logic         r_orphan;   // a reset abandoned a request whose response may still arrive

    logic [31:0]  w_pc_plus4;
    logic         w_req_valid;
    logic         w_accept;

    // Request decode and IF/ID outputs; in FULL the next request targets
    // pc+4 so the fetch of the following word overlaps its consumption.
    always_comb begin
        w_pc_plus4  = r_pc + 32'd4;
        w_req_valid = 1'b0;
        if (!reset && !PCSrcE)
            w_req_valid = (r_state == EMPTY) || ((r_state == FULL) && !StallF);
        w_accept            = w_req_valid && imem.imem_req_ready;
        imem.imem_req_valid = w_req_valid;
        imem.imem_addr      = (r_state == FULL) ? w_pc_plus4 : r_pc;
        InstrValidF         = (r_state == FULL);
        InstrF              = (r_state == FULL) ? r_buf : NOP_INSTR;
        PCF                 = r_pc;
        PCPlus4F            = w_pc_plus4;
    end

    // FSM, pc and instruction buffer; redirect always beats stall and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= EMPTY;
            r_pc     <= RESET_PC;
            r_buf    <= NOP_INSTR;
            r_orphan <= (r_orphan || (r_state == WAIT) || (r_state == WAIT_DISCARD))
                        && !imem.imem_rsp_valid;
        end else begin
            if (imem.imem_rsp_valid)
                r_orphan <= 1'b0;
            case (r_state)
                EMPTY: begin
                    if (PCSrcE)
                        r_pc <= PCTargetE;
                    else if (w_accept)
                        r_state <= WAIT;
                end
                WAIT: begin
                    if (PCSrcE) begin
                        r_pc    <= PCTargetE;
                        r_state <= imem.imem_rsp_valid ? EMPTY : WAIT_DISCARD;
                    end else if (imem.imem_rsp_valid) begin
                        r_buf   <= imem.imem_rsp_data;
                        r_state <= FULL;
                    end
                end
                WAIT_DISCARD: begin
                    if (PCSrcE)
                        r_pc <= PCTargetE;
                    if (imem.imem_rsp_valid)
                        r_state <= EMPTY;
                end
                FULL: begin
                    if (PCSrcE) begin
                        r_pc    <= PCTargetE;
                        r_state <= EMPTY;
                    end else if (!StallF) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= w_accept ? WAIT : EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    // A response is only legal while a request is outstanding, or as the
    // late answer to a request abandoned by reset.
    a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
        imem.imem_rsp_valid |-> ((r_state == WAIT) || (r_state == WAIT_DISCARD) || r_orphan));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect/
// memory timing, with a program-order scoreboard of expected instructions.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;

    fetch_unit_if imem();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem        (imem),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .InstrValidF (InstrValidF)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_consumed = 0;

    // Program-order scoreboard: PC of the next instruction decode must receive.
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    // Memory responder state.
    logic        pend;
    int          cnt;
    int          dly;
    logic [31:0] paddr;

    // Per-cycle trace for the directed scenarios (cycle 0 = reset cycle).
    int          cyc_n;
    bit          lg_rv[64];
    bit          lg_acc[64];
    bit          lg_iv[64];
    logic [31:0] lg_addr[64];
    logic [31:0] lg_pc[64];
    logic [31:0] lg_pc4[64];
    logic [31:0] lg_ins[64];

    logic        prv_rv, prv_acc, prv_rst;
    logic [31:0] prv_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every consumed instruction is popped and compared.
    always @(negedge clk) begin
        if (!reset) begin
            chk("pcplus4", PCPlus4F, PCF + 32'd4);
            if (!InstrValidF)
                chk("nop_fill", InstrF, NOP_INSTR);
            if (PCSrcE)
                chk("req_during_redirect", {31'b0, imem.imem_req_valid}, 32'd0);
            if (InstrValidF && !StallF && !PCSrcE) begin
                n_consumed++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL consume_unexpected: got pc %h expected no instruction", PCF);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("consume_pc", PCF, e);
                    chk("consume_instr", InstrF, mem_word(e));
                end
            end
        end
    end

    // One clock: sample at negedge, then update memory and scoreboard after posedge.
    task automatic cyc();
        logic acc;
        @(negedge clk);
        acc = imem.imem_req_valid && imem.imem_req_ready;
        if (cyc_n < 64) begin
            lg_rv[cyc_n]   = imem.imem_req_valid;
            lg_acc[cyc_n]  = acc;
            lg_iv[cyc_n]   = InstrValidF;
            lg_addr[cyc_n] = imem.imem_addr;
            lg_pc[cyc_n]   = PCF;
            lg_pc4[cyc_n]  = PCPlus4F;
            lg_ins[cyc_n]  = InstrF;
        end
        if (reset)
            chk("req_in_reset", {31'b0, imem.imem_req_valid}, 32'd0);
        else if (prv_rv && !prv_acc && !prv_rst && imem.imem_req_valid)
            chk("addr_stable", imem.imem_addr, prv_addr);
        if (acc && pend) begin
            total++;
            bad++;
            $display("FAIL second_outstanding: got accept at %h expected none", imem.imem_addr);
        end
        prv_rv   = imem.imem_req_valid;
        prv_acc  = acc;
        prv_rst  = reset;
        prv_addr = imem.imem_addr;
        @(posedge clk);
        #1;
        cyc_n++;
        imem.imem_rsp_valid = 1'b0;
        if (acc) begin
            pend  = 1'b1;
            cnt   = dly;
            paddr = prv_addr;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = mem_word(paddr);
                pend = 1'b0;
            end
        end
        if (!prv_rst && exp_q.size() == 0) begin
            model_pc = model_pc + 32'd4;
            exp_q.push_back(model_pc);
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc = pc;
        exp_q.push_back(pc);
    endtask

    task automatic set_redirect(input logic [31:0] t);
        PCSrcE    = 1'b1;
        PCTargetE = t;
        sb_restart(t);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        StallF = 1'b0;
        PCSrcE = 1'b0;
        pend   = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        sb_restart(RESET_PC_DEF);
        cyc_n = 0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        StallF    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
        imem.imem_req_ready = 1'b1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;
        pend = 1'b0; cnt = 0; dly = 1; paddr = 32'h0;
        prv_rv = 1'b0; prv_acc = 1'b0; prv_rst = 1'b1; prv_addr = 32'h0;
        cyc_n = 0;
        sb_restart(RESET_PC_DEF);

        // Streaming with 1-cycle memory, then a 4-cycle stall at pc 0x8.
        dly = 1;
        imem.imem_req_ready = 1'b1;
        do_reset();
        repeat (6) cyc();
        StallF = 1'b1;
        repeat (4) cyc();
        StallF = 1'b0;
        repeat (2) cyc();
        chk("A_rst_rv", lg_rv[0], 32'd0);
        chk("A_c1_iv", lg_iv[1], 32'd0);
        chk("A_c1_instr", lg_ins[1], NOP_INSTR);
        chk("A_c1_pc", lg_pc[1], 32'h0);
        chk("A_c1_pc4", lg_pc4[1], 32'h4);
        chk("A_c1_rv", lg_rv[1], 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("A_acc", lg_acc[1 + 2 * k], 32'd1);
            chk("A_acc_addr", lg_addr[1 + 2 * k], 32'(4 * k));
            chk("A_iv", lg_iv[3 + 2 * k], 32'd1);
            chk("A_iv_pc", lg_pc[3 + 2 * k], 32'(4 * k));
        end
        chk("A_c2_acc", lg_acc[2], 32'd0);
        chk("A_c4_iv", lg_iv[4], 32'd0);
        for (int c = 7; c <= 10; c++) begin
            chk("C_hold_iv", lg_iv[c], 32'd1);
            chk("C_hold_pc", lg_pc[c], 32'h8);
            chk("C_hold_instr", lg_ins[c], mem_word(32'h8));
            chk("C_hold_rv", lg_rv[c], 32'd0);
        end
        chk("C_rel_acc", lg_acc[11], 32'd1);
        chk("C_rel_addr", lg_addr[11], 32'hC);

        // Memory not ready for 3 cycles after reset.
        do_reset();
        imem.imem_req_ready = 1'b0;
        repeat (3) cyc();
        imem.imem_req_ready = 1'b1;
        cyc();
        for (int c = 1; c <= 4; c++) begin
            chk("B_rv", lg_rv[c], 32'd1);
            chk("B_addr", lg_addr[c], 32'h0);
            chk("B_acc", lg_acc[c], (c == 4) ? 32'd1 : 32'd0);
        end
        repeat (4) cyc();

        // Redirect while waiting on 0x4 (2-cycle memory).
        dly = 2;
        do_reset();
        repeat (4) cyc();
        set_redirect(32'h100);
        cyc();
        PCSrcE = 1'b0;
        repeat (6) cyc();
        chk("D_acc4_addr", lg_addr[4], 32'h4);
        chk("D_redir_rv", lg_rv[5], 32'd0);
        for (int c = 5; c <= 9; c++)
            chk("D_no_iv", lg_iv[c], 32'd0);
        chk("D_tgt_acc", lg_acc[7], 32'd1);
        chk("D_tgt_addr", lg_addr[7], 32'h100);
        chk("D_first_iv", lg_iv[10], 32'd1);
        chk("D_first_pc", lg_pc[10], 32'h100);
        chk("D_first_instr", lg_ins[10], mem_word(32'h100));

        // Redirect in the same cycle as the response.
        dly = 1;
        do_reset();
        repeat (3) cyc();
        set_redirect(32'h200);
        cyc();
        PCSrcE = 1'b0;
        repeat (3) cyc();
        chk("E_redir_rv", lg_rv[4], 32'd0);
        chk("E_dropped_iv", lg_iv[5], 32'd0);
        chk("E_next_acc", lg_acc[5], 32'd1);
        chk("E_next_addr", lg_addr[5], 32'h200);
        chk("E_first_pc", lg_pc[7], 32'h200);
        chk("E_first_iv", lg_iv[7], 32'd1);

        // Reset while waiting; the late response lands in EMPTY.
        dly = 3;
        do_reset();
        cyc();
        reset = 1'b1;
        imem.imem_req_ready = 1'b0;
        sb_restart(RESET_PC_DEF);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        imem.imem_req_ready = 1'b1;
        repeat (5) cyc();
        chk("F_rst_rv", lg_rv[2], 32'd0);
        chk("F_post_iv", lg_iv[3], 32'd0);
        chk("F_post_pc", lg_pc[3], 32'h0);
        chk("F_post_rv", lg_rv[3], 32'd1);
        for (int c = 4; c <= 8; c++)
            chk("F_late_ignored", lg_iv[c], 32'd0);
        chk("F_acc", lg_acc[5], 32'd1);
        chk("F_acc_addr", lg_addr[5], 32'h0);
        chk("F_iv", lg_iv[9], 32'd1);
        chk("F_pc", lg_pc[9], 32'h0);
        chk("F_instr", lg_ins[9], mem_word(32'h0));

        // PC wrap at the top of the address space.
        dly = 1;
        do_reset();
        set_redirect(32'hFFFF_FFFC);
        cyc();
        PCSrcE = 1'b0;
        repeat (5) cyc();
        chk("G_redir_rv", lg_rv[1], 32'd0);
        chk("G_acc_addr", lg_addr[2], 32'hFFFF_FFFC);
        chk("G_full_pc", lg_pc[4], 32'hFFFF_FFFC);
        chk("G_full_pc4", lg_pc4[4], 32'h0);
        chk("G_wrap_acc", lg_acc[4], 32'd1);
        chk("G_wrap_addr", lg_addr[4], 32'h0);
        chk("G_wrap_iv_pc", lg_pc[6], 32'h0);

        // Randomized memory timing, stalls and redirects.
        do_reset();
        begin
            int start_n, last_n, idle;
            start_n = n_consumed;
            last_n  = n_consumed;
            idle    = 0;
            for (int i = 0; i < 3000; i++) begin
                imem.imem_req_ready = ($urandom_range(9) < 7);
                dly    = 1 + $urandom_range(2);
                StallF = ($urandom_range(9) < 3);
                if ($urandom_range(19) == 0)
                    set_redirect($urandom());
                else
                    PCSrcE = 1'b0;
                cyc();
                if (n_consumed != last_n) begin
                    last_n = n_consumed;
                    idle   = 0;
                end else begin
                    idle++;
                end
                if (idle > 200) begin
                    total++;
                    bad++;
                    $display("FAIL progress_timeout: got %0d idle cycles expected at most 200", idle);
                    break;
                end
            end
            total++;
            if (n_consumed - start_n < 100) begin
                bad++;
                $display("FAIL random_throughput: got %0d instructions expected at least 100",
                         n_consumed - start_n);
            end
        end
        PCSrcE = 1'b0;
        StallF = 1'b0;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
